// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with registered or first-word-fall-through
// read, occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
//
// Handshake: wr_en is a write request that is accepted when the FIFO is not
// full, or when it is full and a read is accepted in the same cycle. rd_en is
// a read request that is accepted when the FIFO is not empty. With FWFT=0
// the popped word appears on rd_data one cycle later, qualified by a one-cycle
// rd_valid pulse. With FWFT=1 rd_data always shows the head word while
// rd_valid is high, and rd_en pops that word. A rejected request sets the
// matching sticky error flag and changes nothing else.
module param_sync_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              rd_acc;
  logic              wr_acc;

  // Pointer increment with explicit wrap so non-power-of-2 depths never
  // produce an index >= DEPTH.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags are decoded from the registered count only.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept decisions on pre-edge state; a full FIFO can write when it also reads.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      count_q <= count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      if (wr_en & ~wr_acc) overflow_q  <= 1'b1;
      if (rd_en & ~rd_acc) underflow_q <= 1'b1;
    end
  end

  // Storage array; not reset, and a write is suppressed while reset or clr is high.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr && !reset) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; valid whenever data is held.
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      // Registered read: data lands one cycle after an accepted read and holds otherwise.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (clr) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule
